// File: rtl/inst_mem_loader.sv
// Byte-stream instruction memory loader: assembles big-endian words and writes them out.
// Optional halt-word detection is enabled with `define LOADER_HALT_DETECT_EN.
module inst_mem_loader #(
  parameter int NBITS     = 8,
  parameter int INST_BITS = 32,
  parameter int CELLS     = 256
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_start,
  input  logic [7:0]           i_word_cnt,
  input  logic [NBITS-1:0]     i_rx_data,
  input  logic                 i_rx_valid,
  output logic [INST_BITS-1:0] o_dbg_addr,
  output logic [INST_BITS-1:0] o_dbg_inst,
  output logic                 o_dbg_wr_en,
  output logic                 o_busy,
  output logic                 o_done,
  output logic [7:0]           o_words
);

  localparam int WMAX  = CELLS / 4;
  localparam int BYTES = INST_BITS / NBITS;

  localparam logic [7:0] WMAX_W   = 8'(WMAX);
  localparam logic [2:0] LAST_IDX = 3'(BYTES - 1);
  localparam logic [INST_BITS-1:0] ADDR_STEP = INST_BITS'(4);

  typedef enum logic [2:0] {
    IDLE,
    RECV,
    WRITE,
    ADVANCE,
    DONE
  } state_t;

  state_t               state_q, state_d;
  logic [7:0]           n_q, n_d;
  logic [7:0]           words_q, words_d;
  logic [INST_BITS-1:0] addr_q, addr_d;
  logic [INST_BITS-1:0] inst_q, inst_d;
  logic [2:0]           idx_q, idx_d;
  logic                 wr_q, wr_d;

  logic [7:0] cnt_clamp;
  logic [7:0] words_inc;
  logic       halt_w;

  assign cnt_clamp = (32'(i_word_cnt) > WMAX) ? WMAX_W : i_word_cnt;
  assign words_inc = words_q + 8'd1;

`ifdef LOADER_HALT_DETECT_EN
  assign halt_w = &inst_q;
`else
  assign halt_w = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    words_d = words_q;
    addr_d  = addr_q;
    inst_d  = inst_q;
    idx_d   = idx_q;
    wr_d    = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        if (i_start) begin
          n_d     = cnt_clamp;
          words_d = 8'd0;
          addr_d  = '0;
          idx_d   = 3'd0;
          state_d = (cnt_clamp == 8'd0) ? DONE : RECV;
        end
      end
      RECV: begin
        if (i_rx_valid) begin
          inst_d = {inst_q[INST_BITS-NBITS-1:0], i_rx_data};
          idx_d  = idx_q + 3'd1;
          if (idx_q == LAST_IDX) begin
            state_d = WRITE;
          end
        end
      end
      WRITE: begin
        // strobe rises one cycle after the word is latched
        wr_d    = 1'b1;
        state_d = ADVANCE;
      end
      ADVANCE: begin
        words_d = words_inc;
        idx_d   = 3'd0;
        // address stays on the last written word so it never passes the top
        if (words_inc == n_q || halt_w) begin
          state_d = DONE;
        end else begin
          addr_d  = addr_q + ADDR_STEP;
          state_d = RECV;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      n_q     <= 8'd0;
      words_q <= 8'd0;
      addr_q  <= '0;
      inst_q  <= '0;
      idx_q   <= 3'd0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      words_q <= words_d;
      addr_q  <= addr_d;
      inst_q  <= inst_d;
      idx_q   <= idx_d;
      wr_q    <= wr_d;
    end
  end

  assign o_dbg_addr  = addr_q;
  assign o_dbg_inst  = inst_q;
  assign o_dbg_wr_en = wr_q;
  assign o_words     = words_q;
  assign o_busy      = (state_q == RECV) ||
                       (state_q == WRITE) ||
                       (state_q == ADVANCE);
  assign o_done      = (state_q == DONE);

endmodule

// File: tb/tb_inst_mem_loader.sv
// Directed bench for inst_mem_loader.
// Captures each write strobe and checks words, addresses and status.
module tb_inst_mem_loader;

  logic        i_clk;
  logic        i_rst;
  logic        i_start;
  logic [7:0]  i_word_cnt;
  logic [7:0]  i_rx_data;
  logic        i_rx_valid;
  logic [31:0] o_dbg_addr;
  logic [31:0] o_dbg_inst;
  logic        o_dbg_wr_en;
  logic        o_busy;
  logic        o_done;
  logic [7:0]  o_words;

  int checks = 0;
  int errors = 0;

  logic [31:0] wa[$];
  logic [31:0] wi[$];
  logic        prev_wr   = 1'b0;
  logic [31:0] prev_addr = '0;
  logic [31:0] prev_inst = '0;

  inst_mem_loader dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_start     (i_start),
    .i_word_cnt  (i_word_cnt),
    .i_rx_data   (i_rx_data),
    .i_rx_valid  (i_rx_valid),
    .o_dbg_addr  (o_dbg_addr),
    .o_dbg_inst  (o_dbg_inst),
    .o_dbg_wr_en (o_dbg_wr_en),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_words     (o_words)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // log writes and confirm data/address were held before the strobe
  always @(negedge i_clk) begin
    if (o_dbg_wr_en) begin
      wa.push_back(o_dbg_addr);
      wi.push_back(o_dbg_inst);
      if (!prev_wr) begin
        check("hold_inst", o_dbg_inst, prev_inst);
        check("hold_addr", o_dbg_addr, prev_addr);
      end
    end
    prev_wr   = o_dbg_wr_en;
    prev_addr = o_dbg_addr;
    prev_inst = o_dbg_inst;
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic start(input logic [7:0] n);
    i_start    = 1'b1;
    i_word_cnt = n;
    tick();
    i_start    = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    i_rx_data  = b;
    i_rx_valid = 1'b1;
    tick();
    i_rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) begin
      send_byte(w[31-8*i -: 8]);
    end
    tick();
    tick();
  endtask

  task automatic clear_log();
    wa.delete();
    wi.delete();
  endtask

  initial begin
    logic [31:0] w;
    i_rst      = 1'b1;
    i_start    = 1'b0;
    i_word_cnt = 8'd0;
    i_rx_data  = 8'd0;
    i_rx_valid = 1'b0;
    #2;
    check("rst_addr", o_dbg_addr, 32'd0);
    check("rst_inst", o_dbg_inst, 32'd0);
    check("rst_wr", 32'(o_dbg_wr_en), 32'd0);
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_done", 32'(o_done), 32'd0);
    check("rst_words", 32'(o_words), 32'd0);
    tick();
    tick();
    i_rst = 1'b0;
    tick();

    // two-word load
    clear_log();
    start(8'd2);
    check("t1_busy", 32'(o_busy), 32'd1);
    check("t1_done0", 32'(o_done), 32'd0);
    send_word(32'h12345678);
    send_word(32'hAABBCCDD);
    check("t1_nwr", wa.size(), 32'd2);
    check("t1_i0", wi[0], 32'h12345678);
    check("t1_a0", wa[0], 32'd0);
    check("t1_i1", wi[1], 32'hAABBCCDD);
    check("t1_a1", wa[1], 32'd4);
    check("t1_words", 32'(o_words), 32'd2);
    check("t1_done", 32'(o_done), 32'd1);
    check("t1_busy0", 32'(o_busy), 32'd0);

    // zero-length session
    clear_log();
    start(8'd0);
    check("t2_done", 32'(o_done), 32'd1);
    check("t2_busy", 32'(o_busy), 32'd0);
    check("t2_words", 32'(o_words), 32'd0);
    repeat (4) tick();
    check("t2_nwr", wa.size(), 32'd0);

    // count clamped to memory capacity
    clear_log();
    start(8'd200);
    for (int k = 0; k < 64; k++) begin
      w = {8'(k), 8'(k + 1), 8'hC3, ~8'(k)};
      send_word(w);
    end
    repeat (3) tick();
    check("t3_nwr", wa.size(), 32'd64);
    check("t3_alast", wa[63], 32'd252);
    check("t3_ilast", wi[63], 32'h3F40C3C0);
    check("t3_a17", wa[17], 32'd68);
    check("t3_i17", wi[17], 32'h1112C3EE);
    check("t3_words", 32'(o_words), 32'd64);
    check("t3_done", 32'(o_done), 32'd1);
    check("t3_addr", o_dbg_addr, 32'd252);

    // reset mid-word
    clear_log();
    start(8'd3);
    send_byte(8'h9A);
    send_byte(8'hBC);
    i_rst = 1'b1;
    #2;
    check("t4_addr", o_dbg_addr, 32'd0);
    check("t4_inst", o_dbg_inst, 32'd0);
    check("t4_busy", 32'(o_busy), 32'd0);
    check("t4_done", 32'(o_done), 32'd0);
    check("t4_words", 32'(o_words), 32'd0);
    tick();
    i_rst = 1'b0;
    repeat (3) tick();
    check("t4_nwr", wa.size(), 32'd0);
    start(8'd1);
    send_word(32'h01020304);
    check("t4_nwr2", wa.size(), 32'd1);
    check("t4_i0", wi[0], 32'h01020304);
    check("t4_a0", wa[0], 32'd0);
    check("t4_done2", 32'(o_done), 32'd1);

    // all-ones word
    clear_log();
    start(8'd5);
    send_word(32'h11111111);
    send_word(32'hFFFFFFFF);
    check("t5_i1", wi[1], 32'hFFFFFFFF);
`ifdef LOADER_HALT_DETECT_EN
    check("t5_nwr", wa.size(), 32'd2);
    check("t5_words", 32'(o_words), 32'd2);
    check("t5_done", 32'(o_done), 32'd1);
`else
    check("t5_busy", 32'(o_busy), 32'd1);
    send_word(32'h22222222);
    send_word(32'h33333333);
    send_word(32'h44444444);
    check("t5_nwr", wa.size(), 32'd5);
    check("t5_a4", wa[4], 32'd16);
    check("t5_words", 32'(o_words), 32'd5);
    check("t5_done", 32'(o_done), 32'd1);
`endif

    // stray byte in WRITE and start while busy
    clear_log();
    start(8'd2);
    for (int i = 0; i < 4; i++) begin
      send_byte(8'hA1 + 8'(i));
    end
    send_byte(8'h55);
    tick();
    start(8'd9);
    send_word(32'hB1B2B3B4);
    check("t6_nwr", wa.size(), 32'd2);
    check("t6_i0", wi[0], 32'hA1A2A3A4);
    check("t6_a0", wa[0], 32'd0);
    check("t6_i1", wi[1], 32'hB1B2B3B4);
    check("t6_a1", wa[1], 32'd4);
    check("t6_words", 32'(o_words), 32'd2);
    check("t6_done", 32'(o_done), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
